// File: rtl/beta_pkg.sv
// Shared types and constants for the beta execute-stage load/store unit.
// Holds the FSM state type, access-size/op encodings and the alignment check.
package beta_pkg;

    localparam int LSU_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        WAIT  = 2'b10,
        FAULT = 2'b11
    } lsu_state_t;

    localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
    localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
    localparam logic [1:0] LSU_SIZE_WORD = 2'b10;
    localparam logic [1:0] LSU_SIZE_RSVD = 2'b11;

    localparam logic LSU_OP_LOAD  = 1'b0;
    localparam logic LSU_OP_STORE = 1'b1;

    // True when an access can never reach the bus: reserved size or misaligned.
    function automatic logic lsu_addr_fault(input logic [1:0] size, input logic [1:0] offset);
        logic fault;
        case (size)
            LSU_SIZE_BYTE: fault = 1'b0;
            LSU_SIZE_HALF: fault = offset[0];
            LSU_SIZE_WORD: fault = (offset != 2'b00);
            default:       fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/beta_exe_lsu_if.sv
// Data-bus interface between the LSU (master) and memory (slave).
interface beta_exe_lsu_if;
    // Handshake: the master raises data_req_o and holds data_addr_o, data_we_o,
    // data_be_o and data_wdata_o stable until a cycle with data_gnt_i high; the
    // slave then returns exactly one data_rvalid_i pulse in a later cycle, and
    // data_rdata_i / data_err_i are only meaningful while data_rvalid_i is high.
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );

    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );
endinterface

// File: rtl/beta_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-data extraction with zero/sign extension.
module beta_lsu_align
    import beta_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] bus_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] lane_wdata_o,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted      = bus_rdata_i >> {offset_i, 3'b000};
        be_o         = 4'b0000;
        lane_wdata_o = '0;
        load_data_o  = '0;
        case (size_i)
            LSU_SIZE_BYTE: begin
                be_o         = 4'b0001 << offset_i;
                lane_wdata_o = {4{wdata_i[7:0]}};
                load_data_o  = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
            end
            LSU_SIZE_HALF: begin
                be_o         = 4'b0011 << {offset_i[1], 1'b0};
                lane_wdata_o = {2{wdata_i[15:0]}};
                load_data_o  = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            end
            LSU_SIZE_WORD: begin
                be_o         = 4'b1111;
                lane_wdata_o = wdata_i;
                load_data_o  = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/beta_exe_lsu.sv
// Execute-stage load/store unit: accepts one request at a time from the exe
// control unit, runs a single req/gnt/rvalid bus transaction and reports status.
module beta_exe_lsu
    import beta_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 lsu_en_i,
    input  logic                 lsu_op_i,
    input  logic [1:0]           lsu_op_size_i,
    input  logic                 lsu_unsigned_i,
    input  logic [DataWidth-1:0] lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_busy_o,
    output logic [DataWidth-1:0] lsu_rdata_o,
    output logic                 lsu_err_o,
    output lsu_state_t           state_o,
    beta_exe_lsu_if.master       bus
);

    lsu_state_t  state_q, state_d;
    logic        accept;
    logic        rsp_done;

    logic        op_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    beta_lsu_align u_align (
        .size_i       (size_q),
        .unsigned_i   (unsigned_q),
        .offset_i     (addr_q[1:0]),
        .wdata_i      (wdata_q),
        .bus_rdata_i  (bus.data_rdata_i),
        .be_o         (lane_be),
        .lane_wdata_o (lane_wdata),
        .load_data_o  (load_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Bus outputs come only from the registered state and captured operands,
    // so they are zero outside REQ and cannot move while waiting for grant.
    always_comb begin
        state_d           = state_q;
        accept            = 1'b0;
        rsp_done          = 1'b0;
        bus.data_req_o    = 1'b0;
        bus.data_addr_o   = '0;
        bus.data_we_o     = 1'b0;
        bus.data_be_o     = 4'b0000;
        bus.data_wdata_o  = '0;
        case (state_q)
            IDLE: begin
                if (lsu_en_i) begin
                    accept  = 1'b1;
                    state_d = lsu_addr_fault(lsu_op_size_i, lsu_addr_i[1:0]) ? FAULT : REQ;
                end
            end
            REQ: begin
                bus.data_req_o   = 1'b1;
                bus.data_addr_o  = {addr_q[31:2], 2'b00};
                bus.data_we_o    = op_q;
                bus.data_be_o    = lane_be;
                bus.data_wdata_o = lane_wdata;
                if (bus.data_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (bus.data_rvalid_i) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q       <= LSU_OP_LOAD;
            size_q     <= LSU_SIZE_BYTE;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= lsu_op_i;
                size_q     <= lsu_op_size_i;
                unsigned_q <= lsu_unsigned_i;
                addr_q     <= lsu_addr_i;
                wdata_q    <= lsu_wdata_i;
                err_q      <= 1'b0;
            end
            if (state_q == FAULT) err_q <= 1'b1;
            // A load that returns a bus error keeps the previous good result.
            if (rsp_done) begin
                err_q <= bus.data_err_i;
                if (op_q == LSU_OP_LOAD && !bus.data_err_i) rdata_q <= load_data;
            end
        end
    end

    assign lsu_busy_o  = (state_q != IDLE);
    assign lsu_rdata_o = rdata_q;
    assign lsu_err_o   = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_beta_exe_lsu.sv
// Directed bench for beta_exe_lsu: a transaction-level model predicts every
// output each cycle, and literal expectations pin the model on key vectors.
module tb_beta_exe_lsu;
    import beta_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_en_i, lsu_op_i, lsu_unsigned_i;
    logic [1:0]  lsu_op_size_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_busy_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    lsu_state_t  state_o;

    beta_exe_lsu_if bus_if ();

    beta_exe_lsu #(.DataWidth(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .lsu_en_i(lsu_en_i), .lsu_op_i(lsu_op_i),
        .lsu_op_size_i(lsu_op_size_i), .lsu_unsigned_i(lsu_unsigned_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_busy_o(lsu_busy_o),
        .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o), .state_o(state_o), .bus(bus_if)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // model state
    logic        m_busy = 1'b0, m_req = 1'b0, m_we = 1'b0, m_err = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_be = '0;
    logic [31:0] exp_q[$];
    logic        cmp_on = 1'b0;

    // observation of the last transaction
    int          busy_len;
    logic        req_seen;
    logic [3:0]  last_be;
    logic [31:0] last_addr, last_wdata;
    logic        last_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic m_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || ((int'(a[1:0]) % nbytes(sz)) != 0);
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
        logic [7:0] m;
        m = 8'((1 << nbytes(sz)) - 1) << int'(a[1:0]);
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_lanes(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rd);
        logic [63:0] v, mask;
        v    = 64'(rd) >> (8 * int'(a[1:0]));
        mask = (64'd1 << (8 * nbytes(sz))) - 64'd1;
        v    = v & mask;
        if (!uns && v[8*nbytes(sz)-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // scoreboard compare: every cycle, away from the active edge
    always @(negedge clk_i) begin
        if (cmp_on) begin
            check("busy", 32'(lsu_busy_o), 32'(m_busy));
            check("req", 32'(bus_if.data_req_o), 32'(m_req));
            check("rdata", lsu_rdata_o, m_rdata);
            check("err", 32'(lsu_err_o), 32'(m_err));
            if (m_req) begin
                check("bus_addr", bus_if.data_addr_o, m_addr);
                check("bus_we", 32'(bus_if.data_we_o), 32'(m_we));
                check("bus_be", 32'(bus_if.data_be_o), 32'(m_be));
                check("bus_wdata", bus_if.data_wdata_o, m_wdata);
            end
            if (lsu_busy_o) busy_len++;
            if (bus_if.data_req_o) begin
                req_seen   = 1'b1;
                last_be    = bus_if.data_be_o;
                last_addr  = bus_if.data_addr_o;
                last_wdata = bus_if.data_wdata_o;
                last_we    = bus_if.data_we_o;
            end
        end
    end

    // driver: called just after a rising edge with the DUT idle
    task automatic do_op(input logic op, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input int gnt_dly,
                         input logic [31:0] rd, input logic berr, input logic hold_en);
        lsu_en_i = 1'b1; lsu_op_i = op; lsu_op_size_i = sz; lsu_unsigned_i = uns;
        lsu_addr_i = a; lsu_wdata_i = wd;
        busy_len = 0; req_seen = 1'b0;
        @(posedge clk_i); #1;
        m_busy = 1'b1; m_err = 1'b0;
        if (hold_en) begin
            lsu_addr_i = a ^ 32'h0000_0F0F; lsu_wdata_i = ~wd; lsu_op_i = ~op;
            lsu_op_size_i = 2'd3;
        end else lsu_en_i = 1'b0;
        if (m_bad(sz, a)) begin
            @(posedge clk_i); #1;
            lsu_en_i = 1'b0; m_busy = 1'b0; m_err = 1'b1;
        end else begin
            m_req = 1'b1; m_addr = {a[31:2], 2'b00}; m_we = op;
            m_be = exp_be(sz, a); m_wdata = exp_lanes(sz, wd);
            if (op == LSU_OP_LOAD && !berr) exp_q.push_back(exp_load(sz, uns, a, rd));
            for (int i = 0; i < gnt_dly; i++) begin
                // stray responses while ungranted must be ignored
                bus_if.data_rvalid_i = 1'b1; bus_if.data_err_i = 1'b1;
                bus_if.data_rdata_i = 32'hA5A5_A5A5;
                @(posedge clk_i); #1;
            end
            bus_if.data_rvalid_i = 1'b0; bus_if.data_err_i = 1'b0;
            bus_if.data_gnt_i = 1'b1;
            @(posedge clk_i); #1;
            bus_if.data_gnt_i = 1'b0; m_req = 1'b0;
            bus_if.data_rvalid_i = 1'b1; bus_if.data_rdata_i = rd; bus_if.data_err_i = berr;
            @(posedge clk_i); #1;
            bus_if.data_rvalid_i = 1'b0; bus_if.data_err_i = 1'b0; lsu_en_i = 1'b0;
            m_busy = 1'b0; m_err = berr;
            if (op == LSU_OP_LOAD && !berr) m_rdata = exp_q.pop_front();
        end
        @(posedge clk_i); #1;
    endtask

    initial begin
        rst_i = 1'b1;
        lsu_en_i = 1'b0; lsu_op_i = 1'b0; lsu_op_size_i = 2'd0; lsu_unsigned_i = 1'b0;
        lsu_addr_i = '0; lsu_wdata_i = '0;
        bus_if.data_gnt_i = 1'b0; bus_if.data_rvalid_i = 1'b0;
        bus_if.data_rdata_i = '0; bus_if.data_err_i = 1'b0;
        busy_len = 0; req_seen = 1'b0;
        last_be = '0; last_addr = '0; last_wdata = '0; last_we = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_busy", 32'(lsu_busy_o), 32'd0);
        check("rst_req", 32'(bus_if.data_req_o), 32'd0);
        check("rst_we", 32'(bus_if.data_we_o), 32'd0);
        check("rst_be", 32'(bus_if.data_be_o), 32'd0);
        check("rst_addr", bus_if.data_addr_o, 32'd0);
        check("rst_wdata", bus_if.data_wdata_o, 32'd0);
        check("rst_rdata", lsu_rdata_o, 32'd0);
        check("rst_err", 32'(lsu_err_o), 32'd0);
        check("rst_state", 32'(state_o), 32'(IDLE));
        rst_i = 1'b0; cmp_on = 1'b1;
        @(posedge clk_i); #1;

        // word store, immediate grant
        do_op(LSU_OP_STORE, LSU_SIZE_WORD, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 1'b0);
        check("ws_be", 32'(last_be), 32'hF);
        check("ws_addr", last_addr, 32'h1000_0004);
        check("ws_we", 32'(last_we), 32'd1);
        check("ws_wdata", last_wdata, 32'hDEAD_BEEF);
        check("ws_busy_len", 32'(busy_len), 32'd2);
        check("ws_err", 32'(lsu_err_o), 32'd0);

        // signed / unsigned byte loads from the top lane
        do_op(LSU_OP_LOAD, LSU_SIZE_BYTE, 1'b0, 32'h2000_0003, 32'h0, 0, 32'h8012_3456, 1'b0, 1'b0);
        check("lbs_rdata", lsu_rdata_o, 32'hFFFF_FF80);
        do_op(LSU_OP_LOAD, LSU_SIZE_BYTE, 1'b1, 32'h2000_0003, 32'h0, 0, 32'h8012_3456, 1'b0, 1'b0);
        check("lbu_rdata", lsu_rdata_o, 32'h0000_0080);

        // half store in the upper half; rdata must not move
        do_op(LSU_OP_STORE, LSU_SIZE_HALF, 1'b0, 32'h3000_0002, 32'h1234_ABCD, 0, 32'h0, 1'b0, 1'b0);
        check("hs_be", 32'(last_be), 32'hC);
        check("hs_wdata", last_wdata, 32'hABCD_ABCD);
        check("hs_rdata_kept", lsu_rdata_o, 32'h0000_0080);

        // misaligned word load faults without touching the bus
        do_op(LSU_OP_LOAD, LSU_SIZE_WORD, 1'b0, 32'h4000_0001, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        check("mis_req_seen", 32'(req_seen), 32'd0);
        check("mis_busy_len", 32'(busy_len), 32'd1);
        check("mis_err", 32'(lsu_err_o), 32'd1);
        check("mis_rdata", lsu_rdata_o, 32'h0000_0080);

        // grant withheld 5 cycles, response carries a bus error
        do_op(LSU_OP_STORE, LSU_SIZE_BYTE, 1'b0, 32'h5000_0001, 32'h0000_0055, 5, 32'h0, 1'b1, 1'b0);
        check("slow_err", 32'(lsu_err_o), 32'd1);
        check("slow_busy_len", 32'(busy_len), 32'd7);
        check("slow_be", 32'(last_be), 32'h2);
        check("slow_wdata", last_wdata, 32'h5555_5555);

        // more load shapes; error clears on the next accepted op
        do_op(LSU_OP_LOAD, LSU_SIZE_HALF, 1'b0, 32'h7000_0002, 32'h0, 0, 32'hF00D_1234, 1'b0, 1'b0);
        check("lhs_rdata", lsu_rdata_o, 32'hFFFF_F00D);
        check("err_cleared", 32'(lsu_err_o), 32'd0);
        do_op(LSU_OP_LOAD, LSU_SIZE_WORD, 1'b0, 32'h7000_0010, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 1'b1);
        check("lw_hold_en", lsu_rdata_o, 32'hCAFE_F00D);
        do_op(LSU_OP_LOAD, LSU_SIZE_HALF, 1'b1, 32'h7000_0000, 32'h0, 1, 32'h1234_8001, 1'b0, 1'b0);
        check("lhu_rdata", lsu_rdata_o, 32'h0000_8001);
        do_op(LSU_OP_LOAD, LSU_SIZE_BYTE, 1'b0, 32'h7000_0001, 32'h0, 0, 32'h0000_7F00, 1'b0, 1'b0);
        check("lb_pos", lsu_rdata_o, 32'h0000_007F);

        // reserved size and misaligned half both fault
        do_op(LSU_OP_LOAD, LSU_SIZE_RSVD, 1'b0, 32'h7000_0000, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        check("rsvd_err", 32'(lsu_err_o), 32'd1);
        check("rsvd_busy_len", 32'(busy_len), 32'd1);
        do_op(LSU_OP_LOAD, LSU_SIZE_HALF, 1'b0, 32'h7000_0003, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        check("mish_req_seen", 32'(req_seen), 32'd0);
        check("mish_rdata", lsu_rdata_o, 32'h0000_007F);

        // reset during WAIT, then a late response
        lsu_en_i = 1'b1; lsu_op_i = LSU_OP_LOAD; lsu_op_size_i = LSU_SIZE_WORD;
        lsu_unsigned_i = 1'b0; lsu_addr_i = 32'h6000_0008; lsu_wdata_i = '0;
        @(posedge clk_i); #1;
        lsu_en_i = 1'b0; m_busy = 1'b1; m_err = 1'b0;
        m_req = 1'b1; m_addr = 32'h6000_0008; m_we = 1'b0; m_be = 4'hF; m_wdata = '0;
        bus_if.data_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        bus_if.data_gnt_i = 1'b0; m_req = 1'b0;
        check("pre_rst_state", 32'(state_o), 32'(WAIT));
        rst_i = 1'b1; m_busy = 1'b0; m_rdata = '0; m_err = 1'b0;
        #1;
        check("arst_busy", 32'(lsu_busy_o), 32'd0);
        check("arst_req", 32'(bus_if.data_req_o), 32'd0);
        check("arst_rdata", lsu_rdata_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        bus_if.data_rvalid_i = 1'b1; bus_if.data_rdata_i = 32'hFFFF_FFFF; bus_if.data_err_i = 1'b1;
        @(posedge clk_i); #1;
        bus_if.data_rvalid_i = 1'b0; bus_if.data_err_i = 1'b0;
        @(posedge clk_i); #1;
        check("late_state", 32'(state_o), 32'(IDLE));
        check("late_rdata", lsu_rdata_o, 32'd0);
        check("late_err", 32'(lsu_err_o), 32'd0);
        check("late_be", 32'(bus_if.data_be_o), 32'd0);

        // recovery after reset
        do_op(LSU_OP_LOAD, LSU_SIZE_WORD, 1'b1, 32'h6000_0008, 32'h0, 0, 32'h0BAD_CAFE, 1'b0, 1'b0);
        check("recover_rdata", lsu_rdata_o, 32'h0BAD_CAFE);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
